// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine on a valid/grant/response data bus.
// Handles lane steering, byte enables, load extension and alignment/funct3 faults.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;
    state_t state, next;
    logic              st_r;
    logic [2:0]        f3_r;
    logic [1:0]        lane_r;
    logic              bad;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [DATA_W-1:0] ext;

    // Loads allow funct3 0,1,2,4,5; stores allow 0,1,2; halves/words must be naturally aligned
    assign bad = (is_store ? funct3 > 3'd2 : (funct3 == 3'd3 || funct3[2:1] == 2'b11))
               || (funct3[1:0] == 2'b01 && addr[0])
               || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);

    assign busy    = state != IDLE;
    assign done    = state == DONE || state == FAULT;
    assign fault   = state == FAULT;
    assign mem_req = state == REQ;
    assign mem_we  = mem_req && st_r;

    assign rbyte = mem_rdata[{lane_r, 3'b000} +: 8];
    assign rhalf = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] selects zero extension (LBU/LHU)
    assign ext = f3_r[1] ? mem_rdata
               : f3_r[0] ? {{16{~f3_r[2] & rhalf[15]}}, rhalf}
               : {{24{~f3_r[2] & rbyte[7]}}, rbyte};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? (bad ? FAULT : REQ) : IDLE;
            REQ:     next = mem_gnt ? WAIT : REQ;
            WAIT:    next = mem_rvalid ? DONE : WAIT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_r      <= 1'b0;
            f3_r      <= 3'd0;
            lane_r    <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            load_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                st_r      <= is_store;
                f3_r      <= funct3;
                lane_r    <= addr[1:0];
                mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= funct3[1] ? store_data
                           : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
                mem_be    <= !is_store ? 4'b1111
                           : funct3[1] ? 4'b1111
                           : (funct3[0] ? 4'b0011 : 4'b0001) << addr[1:0];
            end
            if (state == WAIT && mem_rvalid && !st_r)
                load_data <= ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a done-triggered scoreboard for load_store_unit.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_ld = 32'h0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected {fault, load_data}
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_fault", {31'd0, fault}, {31'd0, e[32]});
                chk("resp_load_data", load_data, e[31:0]);
            end
        end
    end

    // gd = grant delay in cycles; a stray start is pulsed during the first stalled cycle
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int gd,
                          input logic ef, input logic [31:0] eld,
                          input logic [3:0] ebe, input logic [31:0] ew);
        logic [31:0] x;
        x = (ef || st) ? last_ld : eld;
        exp_q.push_back({ef, x});
        last_ld = x;
        is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
        tick();
        start = 1'b0;
        if (ef) begin
            chk("fault_cycle", {28'd0, done, fault, busy, mem_req}, 32'he);
            tick();
            chk("fault_idle", {30'd0, done, busy}, 32'h0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk("req_state", {29'd0, mem_req, busy, done}, 32'h6);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_we", {31'd0, mem_we}, {31'd0, st});
                chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
                if (st) chk("mem_wdata", mem_wdata, ew);
                if (i == gd) mem_gnt = 1'b1;
                else if (i == 0) begin
                    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 32'hFFFF_FFFF;
                end
                tick();
                start = 1'b0;
                mem_gnt = 1'b0;
            end
            chk("wait_state", {29'd0, mem_req, busy, done}, 32'h2);
            mem_rvalid = 1'b1; mem_rdata = rd;
            tick();
            mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_0BAD;
            chk("done_cycle", {29'd0, done, fault, busy}, 32'h5);
            tick();
            chk("post_idle", {30'd0, done, busy}, 32'h0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0;
        store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_ctrl", {27'd0, busy, done, fault, mem_req, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'd0, mem_be}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        reset_n = 1'b1;
        tick();
        access(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 4'b1111, 32'h0);
        access(0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 32'h0000_8001, 4'b1111, 32'h0);
        access(0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 4'b1111, 32'h0);
        access(1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 32'h0, 0, 0, 32'h0, 4'b0010, 32'hABAB_ABAB);
        access(0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h0);
        access(0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h0);
        access(1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 3, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
        access(0, 3'b100, 32'h0000_0002, 32'h0, 32'h12AB_5678, 0, 0, 32'h0000_00AB, 4'b1111, 32'h0);
        access(1, 3'b001, 32'h0000_0302, 32'h0000_CAFE, 32'h0, 1, 0, 32'h0, 4'b1100, 32'hCAFE_CAFE);
        access(0, 3'b010, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF, 4'b1111, 32'h0);
        access(1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h0);
        access(1, 3'b001, 32'h0000_0301, 32'h0, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h0);
        // Abort a load in WAIT with an asynchronous reset, then feed a stray response
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500; start = 1'b1;
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("abort_in_wait", {29'd0, mem_req, busy, done}, 32'h2);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, busy, done, fault, mem_req, mem_we}, 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_be", {28'd0, mem_be}, 32'h0);
        chk("abort_load_data", load_data, 32'h0);
        tick();
        reset_n = 1'b1;
        last_ld = 32'h0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid", {29'd0, busy, done, |load_data}, 32'h0);
        access(0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);
        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes one RV32I load or store per request on a single-port valid/grant/response data-memory bus.
- Handles byte-lane steering, byte enables, sign/zero extension, misalignment and illegal-funct3 faults.
- Drives `busy` to stall the pipeline while an access is in flight.
- Its registered `load_data` is the memory-data input of the 3-way writeback source multiplexer (ALU result / load data / PC+4).

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus/register width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse from execute; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I funct3 of the load/store.
- addr  in  ADDR_W  effective byte address (rs1+imm).
- store_data  in  DATA_W  rs2 value.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the access completes or faults.
- fault  out  1  valid with done: misaligned address or illegal funct3.
- load_data  out  DATA_W  extended load result; held until the next completed load.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response (load data or store ack).
- mem_rdata  in  DATA_W  load word.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, fault, mem_req, mem_we = 0; mem_addr, mem_wdata, load_data = 0; mem_be = 0.
- FSM states: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE, start=1: latch is_store, funct3, addr[1:0], store_data and the aligned address.
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 -> FAULT.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> FAULT.
  - Otherwise -> REQ.
- FAULT: done=1 and fault=1 for one cycle; no bus activity; load_data unchanged; next state IDLE.
- REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until the cycle mem_gnt=1, then -> WAIT. mem_req drops the cycle after the grant.
- WAIT: wait for mem_rvalid, then -> DONE. On a load, capture the extended mem_rdata into load_data on that edge. mem_rvalid outside WAIT is ignored.
- DONE: done=1, fault=0 for one cycle -> IDLE.
- start in any state other than IDLE is ignored; the pipeline stalls on busy.
- Minimum latency with grant in the first REQ cycle and rvalid one cycle later: start at cycle T, done at T+3.
- Load extraction, where lane = addr[1:0]:
  - LB/LBU: mem_rdata[8*lane+7 : 8*lane].
  - LH/LHU: half selected by lane[1].
  - Sign- or zero-extend to 32 bits per funct3.
- Store steering:
  - SB: mem_wdata = {4{store_data[7:0]}}, mem_be = 4'b0001 << lane.
  - SH: mem_wdata = {2{store_data[15:0]}}, mem_be = 4'b0011 << lane.
  - SW: mem_wdata = store_data, mem_be = 4'b1111.
- Loads drive mem_be=4'b1111 and mem_we=0.
- Stores leave load_data unchanged.
- reset_n asserted mid-access (REQ or WAIT): immediate return to IDLE with no done pulse. A late mem_rvalid after reset is ignored.
- Back-to-back: start may be asserted in the cycle after done; no idle gap is required.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF1234 → mem_addr=0x1000, mem_be=4'b1111, mem_we=0; done at T+3 with load_data=0xFFFFFF80, fault=0.
- LHU addr=0x2002, mem_rdata=0x80010000 → load_data=0x00008001. LH with the same data → 0xFFFF8001.
- SB addr=0x0101, store_data=0x123456AB → mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB, mem_addr=0x0100. After the ack, done=1 and load_data is unchanged.
- LW addr=0x0006, and separately funct3=3'b011 → mem_req never asserts; done=1 and fault=1 at T+1; busy high for exactly one cycle.
- SW with mem_gnt held low for 3 cycles → mem_req stays high and mem_addr/mem_wdata/mem_be stay stable for 4 cycles. A start pulse during this window is ignored; done arrives 2 cycles after the grant.
- LW with reset_n pulsed low in WAIT, then a stray mem_rvalid → all outputs return to reset values immediately; no done pulse; the next LW completes normally.
